// File: rtl/mem_arbiter_if.sv
// Request/response bundle between fetch, LSU, the arbiter and the unified memory port.
// Latency: none (wires only).
// Backpressure: ready/valid on requests; responses are in order and cannot be stalled.
// Ports: inst_* fetch request/response, data_* LSU request/response, mem_* memory port.
// slave = arbiter view, master = view of the surrounding requesters and memory.
interface mem_arbiter_if #(
    parameter int Xlen = 64
);
    logic              inst_valid_i;
    logic              inst_ready_o;
    logic [Xlen-1:0]   inst_addr_i;
    logic [Xlen-1:0]   inst_rdata_o;
    logic              inst_rvalid_o;

    logic              data_valid_i;
    logic              data_ready_o;
    logic [Xlen-1:0]   data_addr_i;
    logic              data_we_i;
    logic [Xlen-1:0]   data_wdata_i;
    logic [Xlen/8-1:0] data_wstrb_i;
    logic [Xlen-1:0]   data_rdata_o;
    logic              data_rvalid_o;

    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [Xlen-1:0]   mem_addr_o;
    logic              mem_we_o;
    logic [Xlen-1:0]   mem_wdata_o;
    logic [Xlen/8-1:0] mem_wstrb_o;
    logic [Xlen-1:0]   mem_rdata_i;
    logic              mem_rvalid_i;

    modport slave (
        input  inst_valid_i, inst_addr_i,
        input  data_valid_i, data_addr_i, data_we_i, data_wdata_i, data_wstrb_i,
        input  mem_ready_i, mem_rdata_i, mem_rvalid_i,
        output inst_ready_o, inst_rdata_o, inst_rvalid_o,
        output data_ready_o, data_rdata_o, data_rvalid_o,
        output mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o
    );

    modport master (
        output inst_valid_i, inst_addr_i,
        output data_valid_i, data_addr_i, data_we_i, data_wdata_i, data_wstrb_i,
        output mem_ready_i, mem_rdata_i, mem_rvalid_i,
        input  inst_ready_o, inst_rdata_o, inst_rvalid_o,
        input  data_ready_o, data_rdata_o, data_rvalid_o,
        input  mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory port between fetch and LSU; routes in-order responses back by owner.
// Latency: zero added cycles on request and response paths (pure mux/route).
// Backpressure: winner ready = issue_ok && mem_ready_i; loser ready 0; no issue while owner queue full.
// Ports: clk_i, rst_i (sync active-high), bus (mem_arbiter_if.slave), err_o (sticky orphan-response flag).
module mem_arbiter #(
    parameter int OutstandingLog2 = 2,
    parameter int MaxDataStreak   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_arbiter_if.slave    bus,
    output logic            err_o
);
    localparam int Depth   = 1 << OutstandingLog2;
    localparam int StreakW = $clog2(MaxDataStreak + 1);
    localparam logic [OutstandingLog2:0] DepthC     = (OutstandingLog2 + 1)'(Depth);
    localparam logic [StreakW-1:0]       StreakMaxC = StreakW'(MaxDataStreak);

    logic [OutstandingLog2:0]   cnt_q, cnt_d;
    logic [OutstandingLog2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [Depth-1:0]           owner_q, owner_d;   // 1 = LSU owns the entry
    logic [StreakW-1:0]         streak_q, streak_d;
    logic                       err_q, err_d;

    logic issue_ok, q_empty, streak_full;
    logic grant_data, grant_inst, mem_valid, mem_hs, pop, head_owner;

    // Full queue blocks issue outright; a response arriving this cycle does not
    // free a slot until next cycle, keeping mem_rvalid_i off the request path.
    assign issue_ok    = !rst_i && (cnt_q < DepthC);
    assign q_empty     = (cnt_q == '0);
    assign streak_full = (streak_q == StreakMaxC);

    // LSU wins by default; fetch wins once after MaxDataStreak back-to-back LSU grants.
    assign grant_data = bus.data_valid_i && !(bus.inst_valid_i && streak_full);
    assign grant_inst = bus.inst_valid_i && !grant_data;
    assign mem_valid  = issue_ok && (bus.inst_valid_i || bus.data_valid_i);
    assign mem_hs     = mem_valid && bus.mem_ready_i;

    assign bus.mem_valid_o  = mem_valid;
    assign bus.mem_addr_o   = grant_data ? bus.data_addr_i : bus.inst_addr_i;
    assign bus.mem_we_o     = grant_data && bus.data_we_i;
    assign bus.mem_wdata_o  = bus.data_wdata_i;
    assign bus.mem_wstrb_o  = grant_data ? bus.data_wstrb_i : '0;
    assign bus.inst_ready_o = issue_ok && bus.mem_ready_i && grant_inst;
    assign bus.data_ready_o = issue_ok && bus.mem_ready_i && grant_data;

    assign pop        = !rst_i && bus.mem_rvalid_i && !q_empty;
    assign head_owner = owner_q[rd_q];

    assign bus.inst_rvalid_o = pop && !head_owner;
    assign bus.data_rvalid_o = pop && head_owner;
    assign bus.inst_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o  = bus.mem_rdata_i;
    assign err_o             = err_q;

    always_comb begin
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        err_d    = err_q;

        if (mem_hs && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!mem_hs && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (mem_hs) begin
            owner_d[wr_q] = grant_data;
            wr_d          = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end

        // Streak only counts LSU grants that actually made fetch wait.
        if (!bus.inst_valid_i || (mem_hs && grant_inst)) begin
            streak_d = '0;
        end else if (mem_hs && grant_data && !streak_full) begin
            streak_d = streak_q + 1'b1;
        end

        if (bus.mem_rvalid_i && q_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            owner_q  <= '0;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic vs. a queue-based model.
// Latency: checks combinational outputs mid-cycle, state effects on the following cycle.
// Backpressure: bench memory drives mem_ready_i/mem_rvalid_i, randomly or held off.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic err;
    always #5 clk = ~clk;

    mem_arbiter_if #(.Xlen(64)) bus();

    mem_arbiter #(.OutstandingLog2(2), .MaxDataStreak(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave),
        .err_o (err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: owners of outstanding requests, streak, sticky error.
    bit owners[$];
    int streak;
    bit m_err;

    // Bench memory: accepted requests awaiting a response, in order.
    typedef struct { logic [63:0] addr; bit we; } mreq_t;
    mreq_t memq[$];

    int inst_hs_n, data_hs_n, inst_rv_n, data_rv_n;
    logic [63:0] inst_rdata_log[$];
    bit resp_log[$];
    bit obs_ir, obs_dr, obs_mv, obs_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit iv, input logic [63:0] ia, input bit dv, input logic [63:0] da,
                           input bit we, input logic [63:0] wd, input logic [7:0] ws, input bit mr);
        bus.inst_valid_i = iv;
        bus.inst_addr_i  = ia;
        bus.data_valid_i = dv;
        bus.data_addr_i  = da;
        bus.data_we_i    = we;
        bus.data_wdata_i = wd;
        bus.data_wstrb_i = ws;
        bus.mem_ready_i  = mr;
    endtask

    // Memory returns the oldest pending request with probability pct (when enabled).
    task automatic mem_drive(input bit en, input int pct);
        bit rv;
        rv = en && (memq.size() > 0) && ($urandom_range(0, 99) < pct);
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rv ? memq[0].addr + 64'h1000 : {$urandom, $urandom};
    endtask

    task automatic step();
        bit issue, gd, gi, mv, hs, iv, dv, rv, head_ok, head;
        @(negedge clk);
        iv      = bus.inst_valid_i;
        dv      = bus.data_valid_i;
        rv      = bus.mem_rvalid_i;
        issue   = !rst && (owners.size() < 4);
        gd      = dv && !(iv && streak == 4);
        gi      = iv && !gd;
        mv      = issue && (iv || dv);
        hs      = mv && bus.mem_ready_i;
        head_ok = !rst && rv && (owners.size() > 0);
        head    = (owners.size() > 0) ? owners[0] : 1'b0;

        chk("mem_valid", bus.mem_valid_o, mv);
        chk("inst_ready", bus.inst_ready_o, issue && bus.mem_ready_i && gi);
        chk("data_ready", bus.data_ready_o, issue && bus.mem_ready_i && gd);
        if (mv) begin
            chk("mem_addr", bus.mem_addr_o, gd ? bus.data_addr_i : bus.inst_addr_i);
            chk("mem_we", bus.mem_we_o, gd ? bus.data_we_i : 1'b0);
            chk("mem_wstrb", bus.mem_wstrb_o, gd ? bus.data_wstrb_i : 8'h0);
            if (gd) chk("mem_wdata", bus.mem_wdata_o, bus.data_wdata_i);
        end
        chk("inst_rvalid", bus.inst_rvalid_o, head_ok && !head);
        chk("data_rvalid", bus.data_rvalid_o, head_ok && head);
        chk("inst_rdata", bus.inst_rdata_o, bus.mem_rdata_i);
        chk("data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
        chk("err", err, m_err);

        obs_ir = bus.inst_ready_o;
        obs_dr = bus.data_ready_o;
        obs_mv = bus.mem_valid_o;
        obs_we = bus.mem_we_o;
        if (bus.inst_rvalid_o) begin
            inst_rv_n++;
            inst_rdata_log.push_back(bus.inst_rdata_o);
            resp_log.push_back(1'b0);
        end
        if (bus.data_rvalid_o) begin
            data_rv_n++;
            resp_log.push_back(1'b1);
        end

        @(posedge clk);
        if (rst) begin
            owners.delete();
            memq.delete();
            streak = 0;
            m_err  = 1'b0;
        end else begin
            if (rv) begin
                if (owners.size() > 0) owners.pop_front();
                else m_err = 1'b1;
                if (memq.size() > 0) memq.pop_front();
            end
            if (hs) begin
                owners.push_back(gd);
                memq.push_back('{addr: bus.mem_addr_o, we: bus.mem_we_o});
                if (gi) inst_hs_n++;
                else data_hs_n++;
            end
            if (!iv || (hs && gi)) streak = 0;
            else if (hs && gd && streak < 4) streak++;
        end
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            set_req(0, 0, 0, 0, 0, 0, 0, 1);
            mem_drive(1, 100);
            step();
        end
    endtask

    initial begin
        int ih0;
        rst = 1'b1;
        streak = 0;
        m_err = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        step();
        set_req(1, 64'h40, 1, 64'h80, 1, 64'h5, 8'hff, 1);
        bus.mem_rvalid_i = 1'b1;
        step();
        chk("reset_err", err, 1'b0);
        rst = 1'b0;

        // Fetch-only, 1-cycle memory, addresses 0,4,8.
        inst_hs_n = 0; data_hs_n = 0; inst_rv_n = 0; data_rv_n = 0;
        inst_rdata_log.delete();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 64'(i * 4), 0, 0, 0, 0, 0, 1);
            mem_drive(1, 100);
            step();
        end
        drain(3);
        chk("fetch_hs", 64'(inst_hs_n), 64'd3);
        chk("fetch_rv", 64'(inst_rv_n), 64'd3);
        chk("fetch_data_rv", 64'(data_rv_n), 64'd0);
        for (int i = 0; i < 3; i++)
            chk("fetch_order", (inst_rdata_log.size() > i) ? inst_rdata_log[i] : 64'hx,
                64'h1000 + 64'(i * 4));

        // Both requesting every cycle: D,D,D,D,I repeating.
        drain(2);
        for (int k = 0; k < 10; k++) begin
            set_req(1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 0, 0, 0, 1);
            mem_drive(1, 100);
            step();
            chk("pattern_data", obs_dr, (k % 5) != 4);
            chk("pattern_inst", obs_ir, (k % 5) == 4);
        end
        drain(3);

        // Memory holds responses: only 4 of 6 accepted; a response frees a slot one cycle later.
        ih0 = inst_hs_n;
        for (int k = 0; k < 6; k++) begin
            set_req(1, 64'(k * 8), 0, 0, 0, 0, 0, 1);
            mem_drive(0, 0);
            step();
            chk("bp_mem_valid", obs_mv, k < 4);
        end
        chk("bp_accepted", 64'(inst_hs_n - ih0), 64'd4);
        set_req(1, 64'h100, 0, 0, 0, 0, 0, 1);
        mem_drive(1, 100);
        step();
        chk("bp_no_same_cycle", obs_mv, 1'b0);
        set_req(1, 64'h100, 0, 0, 0, 0, 0, 1);
        mem_drive(0, 0);
        step();
        chk("bp_slot_freed", obs_mv, 1'b1);
        drain(6);

        // Store then fetch: we only on store, responses data then inst.
        resp_log.delete();
        set_req(0, 0, 1, 64'h200, 1, 64'hDEADBEEF, 8'h0f, 1);
        mem_drive(0, 0);
        step();
        chk("store_we", obs_we, 1'b1);
        set_req(1, 64'h300, 0, 0, 0, 0, 0, 1);
        mem_drive(1, 100);
        step();
        chk("fetch_we", obs_we, 1'b0);
        drain(3);
        chk("resp_count", 64'(resp_log.size()), 64'd2);
        chk("resp_first_data", (resp_log.size() > 0) ? resp_log[0] : 1'bx, 1'b1);
        chk("resp_second_inst", (resp_log.size() > 1) ? resp_log[1] : 1'bx, 1'b0);

        // Orphan response: sticky error until reset.
        set_req(0, 0, 0, 0, 0, 0, 0, 1);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h77;
        step();
        drain(1);
        chk("err_set", err, 1'b1);
        drain(3);
        chk("err_sticky", err, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drain(1);
        chk("err_cleared", err, 1'b0);

        // Reset with 3 outstanding: queue emptied, outputs quiet in reset cycle.
        for (int k = 0; k < 3; k++) begin
            set_req(1, 64'(k * 4), 0, 0, 0, 0, 0, 1);
            mem_drive(0, 0);
            step();
        end
        rst = 1'b1;
        set_req(1, 64'h10, 1, 64'h20, 1, 64'h1, 8'h1, 1);
        bus.mem_rvalid_i = 1'b1;
        step();
        chk("rst_mem_valid", obs_mv, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(1, 64'(k * 4), 0, 0, 0, 0, 0, 1);
            mem_drive(0, 0);
            step();
            chk("rst_queue_empty", obs_mv, k < 4);
        end
        drain(6);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_req(1'($urandom_range(0, 1)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), {$urandom, $urandom},
                    8'($urandom), $urandom_range(0, 3) != 0);
            mem_drive(1, 60);
            step();
        end
        drain(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
